// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared nibble width and sequencer state encoding
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ripple_carry_4_bit_adder.sv
// rtl/ripple_carry_4_bit_adder.sv - 4-bit ripple carry adder, the nibble datapath
module ripple_carry_4_bit_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic carry;

    // bit-serial full-adder chain inside one nibble
    always_comb begin
        carry  = cin_i;
        sum_o  = '0;
        for (int i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/serial_nibble_adder.sv
// rtl/serial_nibble_adder.sv - multi-cycle add/subtract, one nibble per clock
module serial_nibble_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              busy_q;
    logic              done_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                ovf_d;

    assign a_nib = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

    ripple_carry_4_bit_adder u_nibble_adder (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout)
    );

    // Only meaningful on the MSB nibble: operand signs agree but result sign differs.
    assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);

    // sequencer: latch operands on start, one nibble per clock, pulse done at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry_q <= nib_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= nib_cout;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// tb/tb_serial_nibble_adder.sv - scoreboard bench for serial_nibble_adder
module tb_serial_nibble_adder;

    localparam int W = 16;
    localparam int LAT = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    serial_nibble_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;
    int   cyc       = 0;
    exp_t mon_e;

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xsub, input logic xcin, input int acc);
        exp_t   e;
        int     sa;
        int     sb;
        int     ci;
        int     r;
        longint u;
        sa = $signed(xa);
        sb = $signed(xb);
        ci = xcin ? 1 : 0;
        if (xsub) begin
            r   = sa - sb;
            e.s = xa - xb;
            e.c = (xa >= xb);
        end else begin
            r   = sa + sb + ci;
            u   = longint'(xa) + longint'(xb) + longint'(ci);
            e.s = u[W-1:0];
            e.c = u[W];
        end
        e.v   = (r > 32767) || (r < -32768);
        e.acc = acc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xsub, input logic xcin);
        wait_idle();
        a     = xa;
        b     = xb;
        sub   = xsub;
        cin   = xcin;
        start = 1'b1;
        tick();
        start = 1'b0;
        q.push_back(model(xa, xb, xsub, xcin, cyc));
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("sum_cleared_on_accept", {16'd0, sum}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", q.size(), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // monitor: every done pulse consumes one expected result
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("sum", {16'd0, sum}, {16'd0, mon_e.s});
                    chk("cout", {31'd0, cout}, {31'd0, mon_e.c});
                    chk("ovf", {31'd0, ovf}, {31'd0, mon_e.v});
                    chk("latency", cyc - mon_e.acc, LAT);
                    chk("busy_with_done", {31'd0, busy}, 32'd1);
                end
            end
        end
    end

    initial begin
        int   d0;
        exp_t he;
        rst   = 1'b1;
        start = 1'b1;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        cin   = 1'b0;
        tick();
        tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sum", {16'd0, sum}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        issue(16'h0001, 16'hFFFF, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h0005, 16'h0007, 1'b1, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b1);
        drain();

        // start pulses while busy must be ignored
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        d0 = done_cnt;
        for (int i = 1; i <= 5; i++) begin
            a     = 16'hFFFF;
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        chk("ignored_start_busy", {31'd0, busy}, 32'd0);
        repeat (6) tick();
        chk("single_done_pulse", done_cnt - d0, 32'd1);
        chk("held_sum_2345", {16'd0, sum}, 32'h2345);

        // reset in the middle of an operation
        issue(16'hABCD, 16'h1111, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        d0 = done_cnt;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (8) tick();
        chk("abort_no_done", done_cnt - d0, 32'd0);
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        drain();

        // carry-in path and result hold
        issue(16'hFFFF, 16'h0000, 1'b0, 1'b1);
        drain();
        he = model(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
        repeat (10) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
        chk("hold_sum", {16'd0, sum}, {16'd0, he.s});
        chk("hold_cout", {31'd0, cout}, {31'd0, he.c});
        chk("hold_ovf", {31'd0, ovf}, {31'd0, he.v});

        repeat (40) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_nibble_adder.md
SERIAL_NIBBLE_ADDER -- requirements
Module: serial_nibble_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; multiple of 4, minimum 8.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-008 SHALL have port cin  input  1  carry-in for add mode; ignored when sub=1.
REQ-009 SHALL have port busy  output  1  high while operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sum  output  WIDTH  result.
REQ-012 SHALL have port cout  output  1  carry-out of MSB nibble (add: carry; sub: 1 = no borrow).
REQ-013 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; NIBBLES = WIDTH/4.
REQ-015 IDLE: start=1 at a clock edge SHALL latch a, effective B (b if sub=0, ~b if sub=1), carry register (cin if sub=0, 1 if sub=1); nibble index := 0; go to RUN.
REQ-016 RUN: each edge SHALL add nibble[idx] of latched A, effective B and carry register with the 4-bit adder, write 4-bit result into sum[4*idx+3:4*idx], store nibble carry-out in carry register, increment idx.
REQ-017 RUN SHALL go to DONE on the edge that processes idx = NIBBLES-1; DONE SHALL go to IDLE on the next edge.
REQ-018 done SHALL be 1 only in DONE; busy SHALL be 1 in RUN and DONE; latency start-accept edge to done = NIBBLES cycles (start sampled at edge n, done high from edge n+NIBBLES to n+NIBBLES+1).
REQ-019 cout SHALL equal final carry register; ovf SHALL be 1 iff latched A MSB equals effective-B MSB and sum MSB differs from it; both valid when done=1.
REQ-020 sum, cout, ovf SHALL hold their values after DONE until the next accepted start (sum cleared to 0 on accept).
REQ-021 start while busy=1 (RUN or DONE) SHALL be ignored; a, b, sub, cin changes after accept SHALL NOT affect the result.
REQ-022 Carry SHALL ripple between nibbles only via carry register; no cross-nibble combinational path.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, busy=0, done=0, overriding start.
REQ-024 Reset mid-operation SHALL discard the operation; no done pulse SHALL follow.

Structure
REQ-025 Shared package adder_pkg SHALL hold NIBBLE_W = 4 and the FSM state encoding (IDLE, RUN, DONE).
REQ-026 Nibble datapath SHALL be one instance of existing ripple_carry_4_bit_adder; sequencing, registers and flags in serial_nibble_adder.

Verification (WIDTH=16)
REQ-027 a=0x0001, b=0xFFFF, sub=0, cin=0 -> done 4 cycles after accept, sum=0x0000, cout=1, ovf=0.
REQ-028 a=0x7FFF, b=0x0001, sub=0, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-029 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-030 Accept a=0x1234, b=0x1111 add; pulse start with a=0xFFFF at cycles 1-5 -> ignored, sum=0x2345, exactly one done pulse.
REQ-031 rst=1 two cycles after accept -> next cycle busy=0, sum=0, no done; following op 0x00FF+0x0001 -> sum=0x0100, cout=0.
REQ-032 cin=1, a=0xFFFF, b=0x0000, sub=0 -> sum=0x0000, cout=1, ovf=0; results held unchanged 10 cycles after done.
